// File: rtl/interval_sched_ctrl_pkg.sv
// Shared types for the interval scheduler: FSM state encoding, bound-table sizing
// and the packed {lb, ub} entry stored per mode.
package interval_sched_ctrl_pkg;

  localparam int unsigned NUM_MODES = 8;
  localparam int unsigned MODE_W    = 3;
  // Table entries hold fp16 bounds.
  localparam int unsigned BOUND_W   = 16;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } state_e;

  typedef struct packed {
    logic [BOUND_W-1:0] lb;
    logic [BOUND_W-1:0] ub;
  } bound_t;

endpackage

// File: rtl/interval_lane_cnt.sv
// Single-lane out-of-interval counter. Define INTERVAL_SCHED_CNT_SAT_EN to make it
// saturate at all ones; otherwise it wraps.
module interval_lane_cnt #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] r_cnt;
  logic             w_hold;

`ifdef INTERVAL_SCHED_CNT_SAT_EN
  assign w_hold = &r_cnt;
`else
  assign w_hold = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      r_cnt <= '0;
    end else if (inc_i && !w_hold) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign cnt_o = r_cnt;

endmodule

// File: rtl/interval_sched_ctrl.sv
// Job controller for the interval-compare datapath: mode bound table, beat sequencing,
// one-cycle registered dp stage and per-lane counters (INTERVAL_SCHED_CNT_SAT_EN: saturate).
module interval_sched_ctrl
  import interval_sched_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned LANES     = 4,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned MAX_ITEMS = 4096
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        cfg_we_i,
  input  logic [MODE_W-1:0]           cfg_mode_i,
  input  logic [WIDTH-1:0]            cfg_lb_i,
  input  logic [WIDTH-1:0]            cfg_ub_i,
  output logic                        cfg_ready_o,
  input  logic                        start_i,
  input  logic [$clog2(MAX_ITEMS):0]  items_i,
  output logic                        busy_o,
  output logic                        done_o,
  input  logic                        s_valid_i,
  output logic                        s_ready_o,
  input  logic [LANES*WIDTH-1:0]      s_score_i,
  input  logic [LANES*MODE_W-1:0]     s_mode_i,
  output logic                        dp_valid_o,
  output logic [LANES-1:0]            dp_lane_en_o,
  output logic [LANES*WIDTH-1:0]      dp_score_o,
  output logic [LANES*WIDTH-1:0]      dp_lb_o,
  output logic [LANES*WIDTH-1:0]      dp_ub_o,
  input  logic [LANES-1:0]            dp_oob_i,
  output logic [LANES*CNT_W-1:0]      cnt_o
);

  localparam int unsigned ITEMS_W = $clog2(MAX_ITEMS) + 1;
  localparam logic [ITEMS_W-1:0] MaxItems = ITEMS_W'(MAX_ITEMS);
  localparam logic [ITEMS_W-1:0] LanesCnt = ITEMS_W'(LANES);

  state_e                 r_state;
  logic [ITEMS_W-1:0]     r_remaining;
  bound_t                 r_tbl [NUM_MODES];

  logic                   r_dp_valid;
  logic [LANES-1:0]       r_lane_en;
  logic [LANES*WIDTH-1:0] r_score;
  logic [LANES*WIDTH-1:0] r_lb;
  logic [LANES*WIDTH-1:0] r_ub;

  logic                   w_accept;
  logic                   w_last;
  logic                   w_clr;
  logic [ITEMS_W-1:0]     w_items;
  logic [ITEMS_W-1:0]     w_step;
  logic [LANES-1:0]       w_lane_en;
  logic [LANES-1:0]       w_inc;
  logic [LANES*WIDTH-1:0] w_lb;
  logic [LANES*WIDTH-1:0] w_ub;

  assign w_accept = (r_state == StRun) && s_valid_i;
  assign w_last   = (r_remaining <= LanesCnt);
  assign w_step   = w_last ? r_remaining : LanesCnt;
  assign w_items  = (items_i > MaxItems) ? MaxItems : items_i;
  assign w_clr    = (r_state == StIdle) && start_i;

  // Final beat enables only the lanes that still carry items.
  always_comb begin
    w_lane_en = '1;
    if (w_last) begin
      for (int i = 0; i < LANES; i++) begin
        w_lane_en[i] = (ITEMS_W'(i) < r_remaining);
      end
    end
  end

  always_comb begin
    w_lb = '0;
    w_ub = '0;
    for (int i = 0; i < LANES; i++) begin
      w_lb[i*WIDTH +: WIDTH] = WIDTH'(r_tbl[s_mode_i[i*MODE_W +: MODE_W]].lb);
      w_ub[i*WIDTH +: WIDTH] = WIDTH'(r_tbl[s_mode_i[i*MODE_W +: MODE_W]].ub);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= StIdle;
      r_remaining <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (start_i) begin
            r_remaining <= w_items;
            r_state     <= (w_items == '0) ? StDone : StRun;
          end
        end
        StRun: begin
          if (w_accept) begin
            r_remaining <= r_remaining - w_step;
            if (w_last) begin
              r_state <= StDrain;
            end
          end
        end
        StDrain: r_state <= StDone;
        StDone:  r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  // Table is only writable while idle so a running job sees stable bounds.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int m = 0; m < NUM_MODES; m++) begin
        r_tbl[m] <= '0;
      end
    end else if (cfg_we_i && cfg_ready_o) begin
      r_tbl[cfg_mode_i] <= bound_t'{lb: BOUND_W'(cfg_lb_i), ub: BOUND_W'(cfg_ub_i)};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_dp_valid <= 1'b0;
      r_lane_en  <= '0;
      r_score    <= '0;
      r_lb       <= '0;
      r_ub       <= '0;
    end else begin
      r_dp_valid <= w_accept;
      if (w_accept) begin
        r_lane_en <= w_lane_en;
        r_score   <= s_score_i;
        r_lb      <= w_lb;
        r_ub      <= w_ub;
      end
    end
  end

  assign w_inc = {LANES{r_dp_valid}} & r_lane_en & dp_oob_i;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    interval_lane_cnt #(
      .CNT_W (CNT_W)
    ) u_lane_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr_i (w_clr),
      .inc_i (w_inc[g]),
      .cnt_o (cnt_o[g*CNT_W +: CNT_W])
    );
  end

  assign cfg_ready_o  = (r_state == StIdle);
  assign s_ready_o    = (r_state == StRun);
  assign busy_o       = (r_state == StRun) || (r_state == StDrain);
  assign done_o       = (r_state == StDone);
  assign dp_valid_o   = r_dp_valid;
  assign dp_lane_en_o = r_lane_en;
  assign dp_score_o   = r_score;
  assign dp_lb_o      = r_lb;
  assign dp_ub_o      = r_ub;

endmodule

// File: doc/interval_sched_ctrl.md
INTERVAL_SCHED_CTRL -- requirements
Module: interval_sched_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 16: score/bound width in bits (fp16).
REQ-002 SHALL have parameter LANES, default 4: scores checked per beat.
REQ-003 SHALL have parameter CNT_W, default 16: per-lane counter width.
REQ-004 SHALL have parameter MAX_ITEMS, default 4096: largest job length.
REQ-005 SHALL have ports: clk_i in 1, clock; rst_i in 1, reset. One clock; reset is synchronous and active-high.
REQ-006 SHALL have ports: cfg_we_i in 1, table write; cfg_mode_i in 3, entry index; cfg_lb_i in WIDTH, lower bound; cfg_ub_i in WIDTH, upper bound; cfg_ready_o out 1, table writable.
REQ-007 SHALL have ports: start_i in 1, job start; items_i in log2(MAX_ITEMS)+1, job length; busy_o out 1; done_o out 1, one-cycle pulse.
REQ-008 SHALL have ports: s_valid_i in 1; s_ready_o out 1; s_score_i in LANES x WIDTH; s_mode_i in LANES x 3.
REQ-009 SHALL have ports: dp_valid_o out 1; dp_lane_en_o out LANES; dp_score_o, dp_lb_o, dp_ub_o out LANES x WIDTH; dp_oob_i in LANES, combinational out-of-interval flags from the compare datapath.
REQ-010 SHALL have port cnt_o out LANES x CNT_W, per-lane out-of-interval counts.

Function
REQ-011 SHALL hold an 8-entry bound table (lb, ub per mode); write occurs on cfg_we_i & cfg_ready_o; cfg_ready_o = 1 only in IDLE; writes outside IDLE are dropped.
REQ-012 SHALL implement FSM IDLE, RUN, DRAIN, DONE.
REQ-013 IDLE: on start_i with items_i > 0, SHALL clear counters, load remaining = items_i, go RUN; with items_i = 0, SHALL go DONE directly, counters cleared.
REQ-014 RUN: s_ready_o = 1; beat accepted on s_valid_i & s_ready_o; remaining decrements by min(remaining, LANES); acceptance of the beat bringing remaining to 0 SHALL go DRAIN.
REQ-015 Each accepted beat SHALL appear on dp_* in the following cycle (latency 1, registered): dp_valid_o = 1, dp_score_o = s_score_i, dp_lb_o/dp_ub_o = table entry selected by each lane's s_mode_i.
REQ-016 dp_lane_en_o SHALL be all ones except on the final beat, where only the lowest min(remaining, LANES) lanes are set.
REQ-017 In any cycle with dp_valid_o, counter i SHALL increment by 1 when dp_lane_en_o[i] & dp_oob_i[i]; disabled lanes never count.
REQ-018 No-beat cycles in RUN SHALL give dp_valid_o = 0 and no counter change; bubbles are unlimited.
REQ-019 DRAIN: lasts exactly one cycle (final dp beat counted), then DONE.
REQ-020 DONE: done_o = 1 for one cycle, then IDLE; cnt_o holds until next start.
REQ-021 busy_o = 1 in RUN and DRAIN; start_i outside IDLE SHALL be ignored.
REQ-022 items_i > MAX_ITEMS SHALL be clamped to MAX_ITEMS.

Reset
REQ-023 Reset SHALL force IDLE; all outputs 0 except cfg_ready_o = 1; counters 0; bound table 0; reset mid-job abandons the job with no done_o.

Configuration
REQ-024 With INTERVAL_SCHED_CNT_SAT_EN defined, counters SHALL saturate at 2^CNT_W-1; without it, counters SHALL wrap modulo 2^CNT_W.

Structure
REQ-025 A shared package SHALL hold the FSM state enum, NUM_MODES = 8, and a packed bound-entry typedef {lb, ub}.
REQ-026 One sub-module, interval_lane_cnt (single lane counter including saturation option), SHALL be instantiated LANES times.

Verification
REQ-027 Table modes 0..7 written, items = 8, all dp_oob_i = 1 -> 2 dp beats, each cnt_o = 2, done_o after DRAIN.
REQ-028 items = 6 -> second beat dp_lane_en_o = 0011; with dp_oob_i = 1111, cnt_o = {1,1,2,2} (lane 3..0).
REQ-029 s_valid_i toggling 1,0,0,1 for items = 8 -> dp_valid_o exactly 2 cycles, counts unaffected by bubbles.
REQ-030 cfg_we_i during RUN with mode 2 -> table entry 2 unchanged, dp_lb_o for mode-2 lanes shows old value.
REQ-031 rst_i asserted during RUN -> next cycle IDLE, cnt_o = 0, no done_o; items = 0 start -> done_o on next cycle.
REQ-032 CNT_W = 2, 5 oob beats on lane 0 -> cnt_o[0] = 3 with INTERVAL_SCHED_CNT_SAT_EN, 1 without.
